// File: rtl/cxrom_read_arbiter.sv
// Shares one byte-wide ROM port between a CPU 4-byte fetch and three golden-model byte readers.
// The ROM returns data one cycle after each read strobe.
module cxrom_read_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    output logic        cpu_ack,
    output logic [31:0] cpu_data,
    input  logic [2:0]  gm_req,
    input  logic [15:0] gm_addr0,
    input  logic [15:0] gm_addr1,
    input  logic [15:0] gm_addr2,
    output logic [2:0]  gm_ack,
    output logic [7:0]  gm_data,
    output logic        rom_rd,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CPU_RD, GM_RD, DONE} state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [1:0]  owner;
    logic [3:0]  ack_mask;
    logic [15:0] base;
    logic [2:0]  cnt;
    logic [1:0]  byte_sel;

    logic [3:0]  req_vec;
    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [15:0] grant_addr;

    // Requester index 0 is the CPU, 1..3 are gm[0..2]; the just-acked requester
    // is masked for one IDLE cycle so a late-dropped req is not granted again.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        req_vec   = {gm_req, cpu_req} & ~ack_mask;
        grant_vld = 1'b0;
        grant_idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req_vec[ptr + 2'(i)]) begin
                grant_vld = 1'b1;
                grant_idx = ptr + 2'(i);
            end
        end
        case (grant_idx)
            2'd0:    grant_addr = cpu_addr;
            2'd1:    grant_addr = gm_addr0;
            2'd2:    grant_addr = gm_addr1;
            default: grant_addr = gm_addr2;
        endcase
    end

    // Capture slot for the byte requested one cycle earlier (cnt 1..4 -> byte 0..3).
    assign byte_sel = cnt[1:0] - 2'd1;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            ack_mask <= 4'd0;
            base     <= 16'd0;
            cnt      <= 3'd0;
            cpu_ack  <= 1'b0;
            gm_ack   <= 3'd0;
            rom_rd   <= 1'b0;
            rom_addr <= 16'd0;
            busy     <= 1'b0;
            cpu_data <= 32'd0;
            gm_data  <= 8'd0;
        end else begin
            ack_mask <= 4'd0;
            cpu_ack  <= 1'b0;
            gm_ack   <= 3'd0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner    <= grant_idx;
                        ptr      <= grant_idx + 2'd1;
                        base     <= grant_addr;
                        cnt      <= 3'd0;
                        rom_rd   <= 1'b1;
                        rom_addr <= grant_addr;
                        busy     <= 1'b1;
                        state    <= (grant_idx == 2'd0) ? CPU_RD : GM_RD;
                    end
                end
                CPU_RD: begin
                    if (cnt != 3'd0)
                        cpu_data[{byte_sel, 3'b000} +: 8] <= rom_data;
                    if (cnt < 3'd3) begin
                        rom_rd   <= 1'b1;
                        rom_addr <= base + {13'd0, cnt} + 16'd1;
                    end else begin
                        rom_rd   <= 1'b0;
                        rom_addr <= 16'd0;
                    end
                    if (cnt == 3'd4) begin
                        cpu_ack <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                GM_RD: begin
                    rom_rd   <= 1'b0;
                    rom_addr <= 16'd0;
                    if (cnt == 3'd0) begin
                        cnt <= 3'd1;
                    end else begin
                        gm_data <= rom_data;
                        gm_ack  <= 3'b001 << (owner - 2'd1);
                        state   <= DONE;
                    end
                end
                default: begin
                    ack_mask <= 4'b0001 << owner;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cxrom_read_arbiter.sv
// Directed bench for cxrom_read_arbiter; the ROM model returns the low byte of the
// previous cycle's rom_addr. Inputs change and outputs are sampled on the falling edge.
module tb_cxrom_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_ack;
    logic [31:0] cpu_data;
    logic [2:0]  gm_req;
    logic [15:0] gm_addr0, gm_addr1, gm_addr2;
    logic [2:0]  gm_ack;
    logic [7:0]  gm_data;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    cxrom_read_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_ack  (cpu_ack),
        .cpu_data (cpu_data),
        .gm_req   (gm_req),
        .gm_addr0 (gm_addr0),
        .gm_addr1 (gm_addr1),
        .gm_addr2 (gm_addr2),
        .gm_ack   (gm_ack),
        .gm_data  (gm_data),
        .rom_rd   (rom_rd),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr[7:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_ack"},  32'(cpu_ack),  32'd0);
        check({tag, "_gm_ack"},   32'(gm_ack),   32'd0);
        check({tag, "_rom_rd"},   32'(rom_rd),   32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_cpu_data"}, cpu_data,      32'd0);
        check({tag, "_gm_data"},  32'(gm_data),  32'd0);
    endtask

    int          exp_order [5] = '{0, 1, 2, 3, 0};
    logic [7:0]  exp_gm    [4] = '{8'h00, 8'h01, 8'h02, 8'h03};
    logic [15:0] exp_cpu_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        int got;
        int cyc;
        int idx;
        int acks;

        rst = 1'b1; cpu_req = 1'b0; cpu_addr = 16'd0;
        gm_req = 3'd0; gm_addr0 = 16'd0; gm_addr1 = 16'd0; gm_addr2 = 16'd0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // All four requesters held: round-robin from ptr=0.
        cpu_req = 1'b1; cpu_addr = 16'h0040;
        gm_req = 3'b111; gm_addr0 = 16'h0101; gm_addr1 = 16'h0202; gm_addr2 = 16'h0303;
        got = 0; cyc = 0;
        while (got < 5 && cyc < 200) begin
            tick();
            cyc++;
            if (cpu_ack || gm_ack != 3'd0) begin
                idx = cpu_ack ? 0 : gm_ack[0] ? 1 : gm_ack[1] ? 2 : 3;
                check("rr_order", 32'(idx), 32'(exp_order[got]));
                check("rr_one_ack", 32'($countones({gm_ack, cpu_ack})), 32'd1);
                if (exp_order[got] == 0)
                    check("rr_cpu_data", cpu_data, 32'h43424140);
                else
                    check("rr_gm_data", 32'(gm_data), 32'(exp_gm[exp_order[got]]));
                got++;
                if (got == 5) begin
                    cpu_req = 1'b0;
                    gm_req  = 3'd0;
                end
            end
        end
        if (got < 5) check("rr_timeout", 32'(got), 32'd5);
        cpu_req = 1'b0; gm_req = 3'd0;
        tick(); tick();
        check("rr_idle_busy", 32'(busy), 32'd0);

        // CPU fetch across the 0xFFFF wrap.
        cpu_req = 1'b1; cpu_addr = 16'hFFFE;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) cpu_addr = 16'h5555;
            check("cpu_rom_rd", 32'(rom_rd), 32'd1);
            check("cpu_rom_addr", 32'(rom_addr), 32'(exp_cpu_addr[k-1]));
            check("cpu_busy", 32'(busy), 32'd1);
        end
        tick();
        check("cpu_t5_rom_rd", 32'(rom_rd), 32'd0);
        check("cpu_t5_rom_addr", 32'(rom_addr), 32'd0);
        check("cpu_t5_ack", 32'(cpu_ack), 32'd0);
        tick();
        check("cpu_t6_ack", 32'(cpu_ack), 32'd1);
        check("cpu_t6_data", cpu_data, 32'h0100FFFE);
        check("cpu_t6_gm_ack", 32'(gm_ack), 32'd0);
        cpu_req = 1'b0;
        tick();
        check("cpu_t7_ack", 32'(cpu_ack), 32'd0);
        check("cpu_t7_data_hold", cpu_data, 32'h0100FFFE);
        check("cpu_t7_busy", 32'(busy), 32'd0);

        // Single golden-model read on port 1.
        gm_req = 3'b010; gm_addr1 = 16'h1205;
        tick();
        check("gm1_rom_rd", 32'(rom_rd), 32'd1);
        check("gm1_rom_addr", 32'(rom_addr), 32'h1205);
        tick();
        check("gm1_t2_rom_rd", 32'(rom_rd), 32'd0);
        check("gm1_t2_ack", 32'(gm_ack), 32'd0);
        tick();
        check("gm1_ack", 32'(gm_ack), 32'b010);
        check("gm1_data", 32'(gm_data), 32'h05);
        check("gm1_cpu_ack", 32'(cpu_ack), 32'd0);
        gm_req = 3'd0;
        tick();
        check("gm1_ack_clear", 32'(gm_ack), 32'd0);
        check("gm1_data_hold", 32'(gm_data), 32'h05);

        // gm_req[0] held one cycle past its ack: only one grant.
        gm_req = 3'b001; gm_addr0 = 16'h0033;
        acks = 0;
        tick(); tick(); tick();
        check("late_ack", 32'(gm_ack), 32'b001);
        check("late_data", 32'(gm_data), 32'h33);
        tick();
        tick();
        gm_req = 3'd0;
        check("late_no_regrant", 32'(busy), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (gm_ack != 3'd0 || cpu_ack) acks++;
        end
        check("late_no_second_ack", 32'(acks), 32'd0);

        // Address change during GM_RD is ignored.
        gm_req = 3'b100; gm_addr2 = 16'h0010;
        tick();
        check("gm2_rom_addr", 32'(rom_addr), 32'h0010);
        gm_addr2 = 16'h0020;
        tick(); tick();
        check("gm2_ack", 32'(gm_ack), 32'b100);
        check("gm2_data", 32'(gm_data), 32'h10);
        gm_req = 3'd0;
        tick();

        // Reset at G+2 of a CPU fetch.
        cpu_req = 1'b1; cpu_addr = 16'h2000;
        tick(); tick();
        check("rstmid_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("rstmid");
        rst = 1'b0; cpu_req = 1'b0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (cpu_ack || gm_ack != 3'd0 || busy) acks++;
        end
        check("rstmid_no_ack", 32'(acks), 32'd0);

        // After reset ptr is 0: CPU beats gm0.
        cpu_req = 1'b1; cpu_addr = 16'h0300;
        gm_req = 3'b001; gm_addr0 = 16'h0077;
        for (int k = 0; k < 6; k++) tick();
        check("ptr_reset_cpu_ack", 32'(cpu_ack), 32'd1);
        check("ptr_reset_gm_ack", 32'(gm_ack), 32'd0);
        check("ptr_reset_cpu_data", cpu_data, 32'h03020100);
        cpu_req = 1'b0;
        tick(); tick(); tick(); tick();
        check("ptr_next_gm_ack", 32'(gm_ack), 32'b001);
        check("ptr_next_gm_data", 32'(gm_data), 32'h77);
        gm_req = 3'd0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
